region_dispatcher: RTL

//  Next-generation HTTP load balancer. Buffers request metadata from the HTTP module and selects a target

---
 rtl/lb_pkg.sv | 19 +
 rtl/region_select.sv | 45 ++++
 rtl/region_dispatcher.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lb_pkg.sv
// Shared types and helpers for the region dispatcher: meta field layout, FSM states,
// and the 32-bit control word used on pr_ctrl and lb_ctrl.
package lb_pkg;

  localparam int OID_LO = 82;
  localparam int OID_W  = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    RECONF   = 2'd2,
    DISPATCH = 2'd3
  } state_t;

  function automatic logic [31:0] pack_ctrl(input logic [7:0] region, input logic [15:0] oid);
    return {1'b1, 7'b0, region, oid};
  endfunction

endpackage

// File: rtl/region_select.sv
// Combinational region choice: lowest-index eligible operator hit, otherwise the
// lowest-index region with the smallest outstanding count (eligibility ignored).
module region_select
  import lb_pkg::*;
#(
  parameter int N_REGIONS         = 4,
  parameter int OPERATOR_ID_WIDTH = 16,
  parameter int CNT_WIDTH         = 8,
  parameter int MAX_OUTSTANDING   = 8,
  parameter int RW                = 2
) (
  input  logic [N_REGIONS*CNT_WIDTH-1:0]         counts,
  input  logic [N_REGIONS*OPERATOR_ID_WIDTH-1:0] oids,
  input  logic [OPERATOR_ID_WIDTH-1:0]           req_oid,
  output logic                                   hit,
  output logic [RW-1:0]                          sel
);

  logic                 found;
  logic [RW-1:0]        hit_idx;
  logic [RW-1:0]        min_idx;
  logic [CNT_WIDTH-1:0] min_cnt;

  always_comb begin
    found   = 1'b0;
    hit_idx = '0;
    min_idx = '0;
    min_cnt = counts[CNT_WIDTH-1:0];
    for (int r = 0; r < N_REGIONS; r++) begin
      if (!found && (counts[r*CNT_WIDTH +: CNT_WIDTH] < CNT_WIDTH'(MAX_OUTSTANDING)) &&
          (oids[r*OPERATOR_ID_WIDTH +: OPERATOR_ID_WIDTH] == req_oid)) begin
        found   = 1'b1;
        hit_idx = RW'(r);
      end
      // Strict less-than keeps the lowest index on ties.
      if (counts[r*CNT_WIDTH +: CNT_WIDTH] < min_cnt) begin
        min_cnt = counts[r*CNT_WIDTH +: CNT_WIDTH];
        min_idx = RW'(r);
      end
    end
    hit = found;
    sel = found ? hit_idx : min_idx;
  end

endmodule

// File: rtl/region_dispatcher.sv
// Buffers HTTP request metadata, picks a target region (affinity, then least outstanding),
// requests partial reconfiguration on a miss and dispatches with per-region in-flight tracking.
module region_dispatcher
  import lb_pkg::*;
#(
  parameter int  HTTP_META_WIDTH   = 98,
  parameter int  OPERATOR_ID_WIDTH = 16,
  parameter int  N_REGIONS         = 4,
  parameter int  QDEPTH            = 16,
  parameter int  CNT_WIDTH         = 8,
  parameter int  MAX_OUTSTANDING   = 8,
  localparam int RW                = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic                                   meta_tvalid,
  output logic                                   meta_tready,
  input  logic [HTTP_META_WIDTH-1:0]             meta_tdata,
  input  logic [N_REGIONS*OPERATOR_ID_WIDTH-1:0] region_oid_in,
  input  logic                                   cmpl_valid,
  input  logic [RW-1:0]                          cmpl_region,
  output logic                                   disp_tvalid,
  input  logic                                   disp_tready,
  output logic [HTTP_META_WIDTH-1:0]             disp_tdata,
  output logic [RW-1:0]                          disp_region,
  output logic [31:0]                            pr_ctrl,
  input  logic                                   pr_done,
  output logic [31:0]                            lb_ctrl,
  output logic                                   err_underflow,
  output logic [1:0]                             fsm_state
);

  // Handshakes: a beat transfers on a rising edge where valid && ready; a producer holds
  // valid and data stable until it transfers. pr_ctrl is a level held until a pr_done pulse.

  localparam int AW   = $clog2(QDEPTH);
  localparam bit POW2 = (N_REGIONS == (1 << RW));

  state_t state, next_state;

  logic [HTTP_META_WIDTH-1:0]       fifo_mem [QDEPTH];
  logic [AW:0]                      wr_ptr, rd_ptr;
  logic                             full, empty, push, pop;

  logic [HTTP_META_WIDTH-1:0]       req_q;
  logic [OID_W-1:0]                 req_oid;
  logic [RW-1:0]                    sel_q, sel_comb;
  logic                             hit_comb;

  logic [CNT_WIDTH-1:0]             cnt [N_REGIONS];
  logic [N_REGIONS*CNT_WIDTH-1:0]   cnt_flat;
  logic [N_REGIONS-1:0]             inc_vec, dec_vec;
  logic                             cmpl_ok, disp_fire, pr_active;
  logic [31:0]                      lb_q;
  logic                             err_q;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = meta_tvalid && !full;
  assign pop     = (state == IDLE) && !empty;
  assign req_oid = req_q[OID_LO +: OID_W];

  assign disp_fire = (state == DISPATCH) && disp_tready;
  // PR may only start once the chosen region has fully drained.
  assign pr_active = (state == RECONF) && (cnt[sel_q] == '0);
  assign cmpl_ok   = cmpl_valid && (POW2 || (32'(cmpl_region) < N_REGIONS));

  always_comb begin
    cnt_flat = '0;
    inc_vec  = '0;
    dec_vec  = '0;
    for (int r = 0; r < N_REGIONS; r++) begin
      cnt_flat[r*CNT_WIDTH +: CNT_WIDTH] = cnt[r];
      inc_vec[r] = disp_fire && (sel_q == RW'(r));
      dec_vec[r] = cmpl_ok && (cmpl_region == RW'(r));
    end
  end

  region_select #(
    .N_REGIONS        (N_REGIONS),
    .OPERATOR_ID_WIDTH(OPERATOR_ID_WIDTH),
    .CNT_WIDTH        (CNT_WIDTH),
    .MAX_OUTSTANDING  (MAX_OUTSTANDING),
    .RW               (RW)
  ) u_select (
    .counts (cnt_flat),
    .oids   (region_oid_in),
    .req_oid(req_q[OID_LO +: OPERATOR_ID_WIDTH]),
    .hit    (hit_comb),
    .sel    (sel_comb)
  );

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (!empty) next_state = SELECT;
      SELECT:   next_state = hit_comb ? DISPATCH : RECONF;
      RECONF:   if (pr_active && pr_done) next_state = DISPATCH;
      DISPATCH: if (disp_tready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= meta_tdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      req_q  <= '0;
      sel_q  <= '0;
      lb_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        req_q  <= fifo_mem[rd_ptr[AW-1:0]];
      end
      if (state == SELECT) sel_q <= sel_comb;
      lb_q <= disp_fire ? pack_ctrl(8'(sel_q), req_oid) : 32'd0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int r = 0; r < N_REGIONS; r++) cnt[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < N_REGIONS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + CNT_WIDTH'(1);
        end else if (dec_vec[r] && !inc_vec[r]) begin
          if (cnt[r] == '0) err_q <= 1'b1;
          else              cnt[r] <= cnt[r] - CNT_WIDTH'(1);
        end
      end
    end
  end

  assign meta_tready   = !full;
  assign disp_tvalid   = (state == DISPATCH);
  assign disp_tdata    = req_q;
  assign disp_region   = sel_q;
  assign pr_ctrl       = pr_active ? pack_ctrl(8'(sel_q), req_oid) : 32'd0;
  assign lb_ctrl       = lb_q;
  assign err_underflow = err_q;
  assign fsm_state     = state;

endmodule
